cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares the single 32-bit backing-memory port between the instruction-cache and data-cache line-transfer paths. Each cache issues whole-line refill (read) or writeback (write) requests. The arbiter grants one client at a time using round-robin and splits the 128-bit line into four sequential 32-bit memory beats. It sits between the cache controllers' save/load handshakes and the memory bus.

## Interface
Parameters:
- `LINE_WORDS`, default 4: 32-bit words per cache line. The line is 16 bytes; all widths below assume 4.
- `ADDR_W`, default 32: address width.

Ports:
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_req`  in  1  I-side line request. Held high until `i_done`.
- `i_we`  in  1  I-side direction: 1 = writeback, 0 = refill.
- `i_addr`  in  32  I-side line address; bits [3:0] are ignored (forced to 0).
- `i_wline`  in  128  I-side writeback line; word k = bits [32k+31:32k].
- `i_rline`  out  128  I-side refilled line.
- `i_done`  out  1  one-cycle completion pulse for the I side.
- `d_req`, `d_we`, `d_addr`, `d_wline`, `d_rline`, `d_done`: same directions, widths and meanings for the D side.
- `mem_req`  out  1  memory beat request.
- `mem_we`  out  1  1 = write beat.
- `mem_addr`  out  32  word address of the beat.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  beat accepted/completed in this cycle.
- `busy`  out  1  high in any state other than IDLE.
- `grant`  out  1  current or last owner: 0 = I, 1 = D.

## Operation
- The FSM has three states: IDLE, BEAT and DONE.
- IDLE:
  - Samples `i_req` and `d_req`.
  - If exactly one is high, that client is granted.
  - If both are high, the client other than the last-granted one wins. The last-granted pointer resets to I, so D wins the first tie after reset.
  - On grant, the FSM latches `we`, the aligned address (`addr & ~0xF`) and `wline` from the winner, updates `grant` and the pointer, clears the beat counter, and moves to BEAT.
- BEAT:
  - `mem_req` = 1.
  - `mem_we` = latched `we`.
  - `mem_addr` = base + 4·beat.
  - `mem_wdata` = latched word[beat].
  - On `mem_ack`:
    - For a refill, `mem_rdata` is written into the granted client's `rline` word[beat].
    - The beat counter increments.
    - If beat was `LINE_WORDS`-1, the FSM moves to DONE.
  - Without `mem_ack`, all outputs hold.
- DONE: the granted client's `done` is high for exactly this cycle, and the FSM returns to IDLE.
- The `rline` registers hold their value until that client's next refill overwrites them. A writeback does not modify `rline`.
- `mem_we`, `mem_addr` and `mem_wdata` are 0 whenever `mem_req` = 0.
- Requests and inputs are sampled only in IDLE. Input changes during BEAT/DONE are ignored; the latched copies are used.
- Clients must deassert `req` on the edge after seeing `done`. A request still high in the IDLE cycle after DONE is treated as a new request.

## Timing
- Reset values: `mem_req`/`mem_we` = 0, `mem_addr`/`mem_wdata` = 0, `i_done`/`d_done` = 0, `busy` = 0, `grant` = 0, `i_rline`/`d_rline` = 0, state IDLE, pointer = I.
- Reset asserted mid-transfer:
  - The next cycle is IDLE with all outputs at reset values.
  - No `done` is issued, and a partially filled `rline` is cleared.
- Latency with zero-wait memory (`mem_ack` high every beat cycle):
  - The request is sampled in cycle 0 (IDLE).
  - Beats occur in cycles 1–4.
  - `done` is high in cycle 5; IDLE resumes in cycle 6.
  - Each wait cycle on `mem_ack` adds one cycle.
- Fairness: a pending request waits at most one full transaction of the other client.
- `busy` = 1 in BEAT and DONE.
- `grant` is valid from cycle 1 and holds through IDLE until the next grant.
- Beat order is always word 0 → 3 (ascending address); there is no critical-word-first ordering.

## Test plan
- I refill, `i_addr`=0x0000_1234, memory returns 0xA0,0xA1,0xA2,0xA3 with ack every cycle -> beats at 0x1230/34/38/3C, `i_done` in cycle 5, `i_rline`=0x000000A3_000000A2_000000A1_000000A0.
- D writeback, `d_addr`=0x80, `d_wline`=0x44_33_22_11 (words) -> `mem_we`=1, `mem_addr` 0x80..0x8C, `mem_wdata` 0x11,0x22,0x33,0x44; `d_rline` unchanged; `d_done` in cycle 5.
- `i_req` and `d_req` both high from reset, each re-requesting immediately after its `done` -> grant order D, I, D, I, and neither `done` is missing.
- Insert 2 idle cycles without `mem_ack` before beat 2 -> outputs hold at beat-2 address/data during the stall; `done` arrives in cycle 7.
- `rst` pulsed during beat 1 of an I refill -> next cycle `mem_req`=0, `busy`=0, `i_rline`=0, no `i_done`; a subsequent tie goes to D.
- `d_addr`/`d_wline` change mid-transfer -> memory still sees the values latched at grant.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
// Word-wide backing-memory bus shared by the I-cache and D-cache line paths.
//   mem_req   : beat request from the arbiter
//   mem_we    : 1 = write beat
//   mem_addr  : byte address of the 32-bit word being transferred
//   mem_wdata : write data
//   mem_rdata : read data, valid while mem_ack is high
//   mem_ack   : beat accepted/completed this cycle
// Modports: master = arbiter side, slave = memory side.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares one 32-bit memory port between the I-cache and D-cache line
// transfers. A whole-line refill or writeback is granted to one client at a
// time (round-robin on ties) and split into LINE_WORDS sequential beats,
// lowest word first.
//   clk, rst            : clock, synchronous active-high reset
//   i_req/i_we/i_addr   : I-side line request, direction, line address
//   i_wline / i_rline   : I-side writeback line in / refilled line out
//   i_done              : one-cycle I-side completion pulse
//   d_*                 : same for the D side
//   mem                 : memory bus (master modport)
//   busy                : transfer in progress (BEAT or DONE)
//   grant               : current/last owner, 0 = I, 1 = D
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic                       i_we,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic [LINE_WORDS*32-1:0]   i_wline,
  output logic [LINE_WORDS*32-1:0]   i_rline,
  output logic                       i_done,
  input  logic                       d_req,
  input  logic                       d_we,
  input  logic [ADDR_W-1:0]          d_addr,
  input  logic [LINE_WORDS*32-1:0]   d_wline,
  output logic [LINE_WORDS*32-1:0]   d_rline,
  output logic                       d_done,
  cache_mem_arbiter_if.master        mem,
  output logic                       busy,
  output logic                       grant
);

  localparam int LINE_W = LINE_WORDS * 32;
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((LINE_WORDS * 4) - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  // grant_q doubles as the round-robin "last granted" pointer
  logic                grant_q, grant_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   i_rline_q, i_rline_d;
  logic [LINE_W-1:0]   d_rline_q, d_rline_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic                busy_q, busy_d;

  // Next-state, latch and output computation
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    beat_d    = beat_q;
    we_d      = we_q;
    base_d    = base_q;
    wline_d   = wline_q;
    i_rline_d = i_rline_q;
    d_rline_d = d_rline_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          // On a tie the client that did not win last time goes next
          if (i_req && d_req) begin
            grant_d = ~grant_q;
          end else begin
            grant_d = d_req;
          end
          if (grant_d) begin
            we_d    = d_we;
            base_d  = d_addr & ALIGN_MASK;
            wline_d = d_wline;
          end else begin
            we_d    = i_we;
            base_d  = i_addr & ALIGN_MASK;
            wline_d = i_wline;
          end
          beat_d  = {BEAT_W{1'b0}};
          state_d = ST_BEAT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BEAT: begin
        if (mem.mem_ack) begin
          if (!we_q) begin
            if (grant_q) begin
              d_rline_d[{beat_q, 5'b00000} +: 32] = mem.mem_rdata;
            end else begin
              i_rline_d[{beat_q, 5'b00000} +: 32] = mem.mem_rdata;
            end
          end else begin
            i_rline_d = i_rline_q;
          end
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BEAT;
          end
        end else begin
          state_d = ST_BEAT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state
    mem_req_d = (state_d == ST_BEAT);
    if (mem_req_d) begin
      mem_we_d    = we_d;
      mem_addr_d  = base_d + ADDR_W'({beat_d, 2'b00});
      mem_wdata_d = wline_d[{beat_d, 5'b00000} +: 32];
    end else begin
      mem_we_d    = 1'b0;
      mem_addr_d  = {ADDR_W{1'b0}};
      mem_wdata_d = 32'h0000_0000;
    end
    i_done_d = (state_d == ST_DONE) && !grant_d;
    d_done_d = (state_d == ST_DONE) && grant_d;
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      beat_q      <= {BEAT_W{1'b0}};
      we_q        <= 1'b0;
      base_q      <= {ADDR_W{1'b0}};
      wline_q     <= {LINE_W{1'b0}};
      i_rline_q   <= {LINE_W{1'b0}};
      d_rline_q   <= {LINE_W{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
      we_q        <= we_d;
      base_q      <= base_d;
      wline_q     <= wline_d;
      i_rline_q   <= i_rline_d;
      d_rline_q   <= d_rline_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign i_rline       = i_rline_q;
  assign d_rline       = d_rline_q;
  assign i_done        = i_done_q;
  assign d_done        = d_done_q;
  assign busy          = busy_q;
  assign grant         = grant_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Directed self-checking bench for cache_mem_arbiter. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge; the memory side
// is played directly by each test task.
module tb_cache_mem_arbiter;

  logic          clk;
  logic          rst;
  logic          i_req, i_we, d_req, d_we;
  logic [31:0]   i_addr, d_addr;
  logic [127:0]  i_wline, d_wline, i_rline, d_rline;
  logic          i_done, d_done, busy, grant;
  int            checks;
  int            errors;

  cache_mem_arbiter_if #(.ADDR_W(32)) mem_if ();

  cache_mem_arbiter #(.LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wline (i_wline),
    .i_rline (i_rline),
    .i_done  (i_done),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wline (d_wline),
    .d_rline (d_rline),
    .d_done  (d_done),
    .mem     (mem_if),
    .busy    (busy),
    .grant   (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1'b0; i_we = 1'b0; i_addr = 32'h0; i_wline = 128'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wline = 128'h0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
    step();
    step();
    checks++;
    if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata} !== 66'h0) begin
      errors++;
      $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h, expected all 0",
               mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata);
    end
    checks++;
    if ({i_done, d_done, busy, grant} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got i_done,d_done,busy,grant=%b expected 0000",
               {i_done, d_done, busy, grant});
    end
    checks++;
    if ((i_rline !== 128'h0) || (d_rline !== 128'h0)) begin
      errors++;
      $display("FAIL reset_rline: got i=%h d=%h expected 0", i_rline, d_rline);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_i_refill();
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_1234;
    step();
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr} !== {1'b1, 1'b0, 32'h1230 + 32'(4 * b)}) begin
        errors++;
        $display("FAIL i_refill_beat%0d: got req=%b we=%b addr=%h expected 1 0 %h",
                 b, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, 32'h1230 + 32'(4 * b));
      end
      checks++;
      if ({i_done, busy, grant} !== 3'b010) begin
        errors++;
        $display("FAIL i_refill_ctrl%0d: got done,busy,grant=%b expected 010", b, {i_done, busy, grant});
      end
      mem_if.mem_ack = 1'b1;
      mem_if.mem_rdata = 32'hA0 + 32'(b);
      step();
    end
    mem_if.mem_ack = 1'b0;
    checks++;
    if ({i_done, d_done, mem_if.mem_req} !== 3'b100) begin
      errors++;
      $display("FAIL i_refill_done: got i_done,d_done,mem_req=%b expected 100", {i_done, d_done, mem_if.mem_req});
    end
    checks++;
    if (i_rline !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
      errors++;
      $display("FAIL i_refill_rline: got %h expected 000000a3000000a2000000a1000000a0", i_rline);
    end
    i_req = 1'b0;
    step();
    checks++;
    if ({i_done, busy, grant} !== 3'b000) begin
      errors++;
      $display("FAIL i_refill_idle: got done,busy,grant=%b expected 000", {i_done, busy, grant});
    end
  endtask

  task automatic test_d_writeback();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80;
    d_wline = {32'h44, 32'h33, 32'h22, 32'h11};
    step();
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata} !==
          {1'b1, 1'b1, 32'h80 + 32'(4 * b), 32'(17 * (b + 1))}) begin
        errors++;
        $display("FAIL d_wb_beat%0d: got req=%b we=%b addr=%h wdata=%h expected 1 1 %h %h",
                 b, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata,
                 32'h80 + 32'(4 * b), 32'(17 * (b + 1)));
      end
      checks++;
      if ({d_done, grant} !== 2'b01) begin
        errors++;
        $display("FAIL d_wb_ctrl%0d: got d_done,grant=%b expected 01", b, {d_done, grant});
      end
      mem_if.mem_ack = 1'b1;
      mem_if.mem_rdata = 32'hDEAD_0000 + 32'(b);
      step();
    end
    mem_if.mem_ack = 1'b0;
    checks++;
    if ({d_done, i_done} !== 2'b10) begin
      errors++;
      $display("FAIL d_wb_done: got d_done,i_done=%b expected 10", {d_done, i_done});
    end
    checks++;
    if (d_rline !== 128'h0) begin
      errors++;
      $display("FAIL d_wb_rline: got %h expected 0", d_rline);
    end
    d_req = 1'b0;
    step();
    checks++;
    if ({d_done, busy, grant} !== 3'b001) begin
      errors++;
      $display("FAIL d_wb_idle: got done,busy,grant=%b expected 001", {d_done, busy, grant});
    end
  endtask

  task automatic test_round_robin();
    logic exp_grant;
    int   i_cnt;
    int   d_cnt;
    i_cnt = 0; d_cnt = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int t = 0; t < 4; t++) begin
      exp_grant = ((t % 2) == 0) ? 1'b1 : 1'b0;
      step();
      checks++;
      if (grant !== exp_grant) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b expected %b", t, grant, exp_grant);
      end
      for (int b = 0; b < 4; b++) begin
        mem_if.mem_ack = 1'b1;
        mem_if.mem_rdata = 32'h0100_0000 * 32'(t + 1) + 32'(b);
        step();
      end
      mem_if.mem_ack = 1'b0;
      if (i_done === 1'b1) i_cnt++;
      if (d_done === 1'b1) d_cnt++;
      checks++;
      if ({d_done, i_done} !== {exp_grant, ~exp_grant}) begin
        errors++;
        $display("FAIL rr_done%0d: got d_done,i_done=%b%b expected %b%b",
                 t, d_done, i_done, exp_grant, ~exp_grant);
      end
      if (exp_grant) d_req = 1'b0; else i_req = 1'b0;
      step();
      if (t < 3) begin
        if (exp_grant) d_req = 1'b1; else i_req = 1'b1;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
    checks++;
    if ((i_cnt != 2) || (d_cnt != 2)) begin
      errors++;
      $display("FAIL rr_counts: got i=%0d d=%0d expected 2 2", i_cnt, d_cnt);
    end
  endtask

  task automatic test_stall();
    logic [1:0] beat_tab [6];
    logic       ack_tab [6];
    beat_tab = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
    ack_tab  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000;
    d_wline = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    step();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wdata, d_done} !==
          {1'b1, 32'h2000 + {28'h0, beat_tab[c], 2'b00}, 32'hD0 + {30'h0, beat_tab[c]}, 1'b0}) begin
        errors++;
        $display("FAIL stall_cycle%0d: got req=%b addr=%h wdata=%h done=%b expected beat %0d",
                 c + 1, mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wdata, d_done, beat_tab[c]);
      end
      mem_if.mem_ack = ack_tab[c];
      step();
    end
    mem_if.mem_ack = 1'b0;
    checks++;
    if (d_done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got d_done=%b in cycle 7 expected 1", d_done);
    end
    d_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h40;
    step();
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h55;
    step();
    mem_if.mem_ack = 1'b0;
    checks++;
    if ({i_rline[31:0], mem_if.mem_addr} !== {32'h55, 32'h44}) begin
      errors++;
      $display("FAIL rstmid_partial: got word0=%h addr=%h expected 55 44", i_rline[31:0], mem_if.mem_addr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; i_req = 1'b0;
    checks++;
    if ({mem_if.mem_req, busy, i_done, grant} !== 4'b0000 || mem_if.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got req,busy,done,grant=%b addr=%h expected 0000 0",
               {mem_if.mem_req, busy, i_done, grant}, mem_if.mem_addr);
    end
    checks++;
    if (i_rline !== 128'h0) begin
      errors++;
      $display("FAIL rstmid_rline: got %h expected 0", i_rline);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if ({i_done, busy} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid_quiet%0d: got i_done,busy=%b expected 00", c, {i_done, busy});
      end
    end
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    step();
    checks++;
    if ({grant, busy} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_tie: got grant,busy=%b expected 11", {grant, busy});
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h0;
      step();
    end
    mem_if.mem_ack = 1'b0;
    checks++;
    if (d_done !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_tie_done: got d_done=%b expected 1", d_done);
    end
    step();
  endtask

  task automatic test_latch_hold();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300;
    d_wline = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    step();
    d_addr = 32'hFFFF_FFF0; d_wline = {128{1'b1}}; d_we = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata} !==
          {1'b1, 32'h300 + 32'(4 * b), 32'h1000 * 32'(b + 1)}) begin
        errors++;
        $display("FAIL latch_beat%0d: got we=%b addr=%h wdata=%h expected 1 %h %h",
                 b, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata,
                 32'h300 + 32'(4 * b), 32'h1000 * 32'(b + 1));
      end
      mem_if.mem_ack = 1'b1;
      step();
    end
    mem_if.mem_ack = 1'b0;
    checks++;
    if (d_done !== 1'b1) begin
      errors++;
      $display("FAIL latch_done: got d_done=%b expected 1", d_done);
    end
    d_req = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_i_refill();
    test_d_writeback();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_latch_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
